// File: rtl/nibble_byte_packer.sv
// rtl/nibble_byte_packer.sv - packs 4-bit nibbles into bytes and queues them in a small FIFO
// Odd trailing nibbles are zero-padded and flagged; head byte is shown in unsigned and signed views.
module nibble_byte_packer #(
   parameter int DEPTH    = 4,
   parameter bit HI_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_nibble,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               out_byte,
   output logic signed [7:0]        out_sbyte,
   output logic                     out_last,
   output logic                     out_padded,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {ST_FIRST, ST_SECOND} state_t;

   state_t                    state_q, state_d;
   logic [3:0]                hold_q, hold_d;
   logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]             level_q, level_d;
   logic [DEPTH-1:0][7:0]     data_q, data_d;
   logic [DEPTH-1:0]          last_q, last_d;
   logic [DEPTH-1:0]          pad_q, pad_d;

   logic       accept;
   logic       push;
   logic       pop;
   logic       new_pad;
   logic [3:0] first_nib;
   logic [3:0] second_nib;
   logic [7:0] new_byte;

   // A full FIFO blocks input even when a pop happens in the same cycle.
   assign in_ready   = (level_q != LW'(DEPTH));
   assign out_valid  = (level_q != '0);
   assign accept     = in_valid && in_ready;
   assign pop        = out_valid && out_ready;

   assign out_byte   = data_q[rd_ptr_q];
   assign out_sbyte  = $signed(data_q[rd_ptr_q]);
   assign out_last   = last_q[rd_ptr_q];
   assign out_padded = pad_q[rd_ptr_q];
   assign level      = level_q;

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      data_d     = data_q;
      last_d     = last_q;
      pad_d      = pad_q;
      push       = 1'b0;
      new_pad    = 1'b0;
      first_nib  = hold_q;
      second_nib = 4'h0;

      case (state_q)
         ST_FIRST: begin
            first_nib = in_nibble;
            if (accept) begin
               if (in_last) begin
                  push    = 1'b1;
                  new_pad = 1'b1;
               end else begin
                  hold_d  = in_nibble;
                  state_d = ST_SECOND;
               end
            end
         end
         ST_SECOND: begin
            second_nib = in_nibble;
            if (accept) begin
               push    = 1'b1;
               state_d = ST_FIRST;
            end
         end
         default: state_d = ST_FIRST;
      endcase

      // The padded nibble always occupies the "second" slot.
      new_byte = HI_FIRST ? {first_nib, second_nib} : {second_nib, first_nib};

      if (push) begin
         data_d[wr_ptr_q] = new_byte;
         last_d[wr_ptr_q] = in_last;
         pad_d[wr_ptr_q]  = new_pad;
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      level_d = level_q + LW'(push) - LW'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_FIRST;
         hold_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         data_q   <= '0;
         last_q   <= '0;
         pad_q    <= '0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         data_q   <= data_d;
         last_q   <= last_d;
         pad_q    <= pad_d;
      end
   end

endmodule

// File: tb/tb_nibble_byte_packer.sv
// tb/tb_nibble_byte_packer.sv - directed self-checking bench for nibble_byte_packer
// Two instances share inputs: hi_* uses HI_FIRST=1, lo_* uses HI_FIRST=0.
module tb_nibble_byte_packer;

   logic clk = 1'b0;
   logic rst;
   logic in_valid;
   logic [3:0] in_nibble;
   logic in_last;
   logic out_ready;

   logic hi_in_ready, hi_out_valid, hi_out_last, hi_out_padded;
   logic [7:0] hi_out_byte;
   logic signed [7:0] hi_out_sbyte;
   logic [2:0] hi_level;

   logic lo_in_ready, lo_out_valid, lo_out_last, lo_out_padded;
   logic [7:0] lo_out_byte;
   logic signed [7:0] lo_out_sbyte;
   logic [2:0] lo_level;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   nibble_byte_packer #(.DEPTH(4), .HI_FIRST(1'b1)) u_hi (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(hi_in_ready), .in_nibble(in_nibble), .in_last(in_last),
      .out_valid(hi_out_valid), .out_ready(out_ready), .out_byte(hi_out_byte),
      .out_sbyte(hi_out_sbyte), .out_last(hi_out_last), .out_padded(hi_out_padded),
      .level(hi_level)
   );

   nibble_byte_packer #(.DEPTH(4), .HI_FIRST(1'b0)) u_lo (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(lo_in_ready), .in_nibble(in_nibble), .in_last(in_last),
      .out_valid(lo_out_valid), .out_ready(out_ready), .out_byte(lo_out_byte),
      .out_sbyte(lo_out_sbyte), .out_last(lo_out_last), .out_padded(lo_out_padded),
      .level(lo_level)
   );

   task automatic drive(input logic v, input logic [3:0] n, input logic l);
      in_valid  = v;
      in_nibble = n;
      in_last   = l;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 4'h0, 1'b0);
      tick();
      n_cmp++; if (hi_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", hi_out_valid); end
      n_cmp++; if (hi_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", hi_level); end
      n_cmp++; if (hi_out_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte got %h want 00", hi_out_byte); end
      n_cmp++; if (hi_out_sbyte !== 8'sd0) begin n_fail++; $display("FAIL reset_sbyte got %0d want 0", hi_out_sbyte); end
      n_cmp++; if ({hi_out_last, hi_out_padded} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {hi_out_last, hi_out_padded}); end
      rst = 1'b0;
      tick();
      n_cmp++; if (hi_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", hi_in_ready); end
      n_cmp++; if (lo_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_lo_in_ready got %b want 1", lo_in_ready); end
   endtask

   task automatic test_pairs();
      out_ready = 1'b1;
      drive(1'b1, 4'hA, 1'b0); tick();
      n_cmp++; if (hi_out_valid !== 1'b0) begin n_fail++; $display("FAIL pair_hold_valid got %b want 0", hi_out_valid); end
      drive(1'b1, 4'h5, 1'b0); tick();
      n_cmp++; if (hi_out_valid !== 1'b1) begin n_fail++; $display("FAIL pair1_valid got %b want 1", hi_out_valid); end
      n_cmp++; if (hi_out_byte !== 8'hA5) begin n_fail++; $display("FAIL pair1_byte got %h want a5", hi_out_byte); end
      n_cmp++; if (hi_out_last !== 1'b0) begin n_fail++; $display("FAIL pair1_last got %b want 0", hi_out_last); end
      n_cmp++; if (lo_out_byte !== 8'h5A) begin n_fail++; $display("FAIL pair1_lo_byte got %h want 5a", lo_out_byte); end
      drive(1'b1, 4'h3, 1'b0); tick();
      n_cmp++; if (hi_out_valid !== 1'b0) begin n_fail++; $display("FAIL pair_popped_valid got %b want 0", hi_out_valid); end
      drive(1'b1, 4'hC, 1'b1); tick();
      n_cmp++; if (hi_out_byte !== 8'h3C) begin n_fail++; $display("FAIL pair2_byte got %h want 3c", hi_out_byte); end
      n_cmp++; if ({hi_out_valid, hi_out_last, hi_out_padded} !== 3'b110) begin n_fail++; $display("FAIL pair2_flags got %b want 110", {hi_out_valid, hi_out_last, hi_out_padded}); end
      n_cmp++; if (lo_out_byte !== 8'hC3) begin n_fail++; $display("FAIL pair2_lo_byte got %h want c3", lo_out_byte); end
      drive(1'b0, 4'h0, 1'b0); tick();
      n_cmp++; if (hi_level !== 3'd0) begin n_fail++; $display("FAIL pair_drain_level got %0d want 0", hi_level); end
      out_ready = 1'b0;
   endtask

   task automatic test_odd_frame();
      out_ready = 1'b0;
      drive(1'b1, 4'h7, 1'b0); tick();
      drive(1'b1, 4'h1, 1'b0); tick();
      drive(1'b1, 4'h9, 1'b1); tick();
      drive(1'b0, 4'h0, 1'b0);
      n_cmp++; if (hi_level !== 3'd2) begin n_fail++; $display("FAIL odd_level got %0d want 2", hi_level); end
      n_cmp++; if (hi_out_byte !== 8'h71) begin n_fail++; $display("FAIL odd_byte1 got %h want 71", hi_out_byte); end
      n_cmp++; if ({hi_out_last, hi_out_padded} !== 2'b00) begin n_fail++; $display("FAIL odd_flags1 got %b want 00", {hi_out_last, hi_out_padded}); end
      n_cmp++; if (lo_out_byte !== 8'h17) begin n_fail++; $display("FAIL odd_lo_byte1 got %h want 17", lo_out_byte); end
      out_ready = 1'b1; tick();
      n_cmp++; if (hi_out_byte !== 8'h90) begin n_fail++; $display("FAIL odd_byte2 got %h want 90", hi_out_byte); end
      n_cmp++; if ({hi_out_last, hi_out_padded} !== 2'b11) begin n_fail++; $display("FAIL odd_flags2 got %b want 11", {hi_out_last, hi_out_padded}); end
      n_cmp++; if (lo_out_byte !== 8'h09) begin n_fail++; $display("FAIL odd_lo_byte2 got %h want 09", lo_out_byte); end
      n_cmp++; if ({lo_out_last, lo_out_padded} !== 2'b11) begin n_fail++; $display("FAIL odd_lo_flags2 got %b want 11", {lo_out_last, lo_out_padded}); end
      tick();
      n_cmp++; if (hi_out_valid !== 1'b0) begin n_fail++; $display("FAIL odd_drain_valid got %b want 0", hi_out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_q [4];
      exp_q = '{8'h34, 8'h56, 8'h78, 8'h9A};
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'(i + 1), 1'b0); tick();
      end
      n_cmp++; if (hi_level !== 3'd4) begin n_fail++; $display("FAIL bp_full_level got %0d want 4", hi_level); end
      n_cmp++; if (hi_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got %b want 0", hi_in_ready); end
      drive(1'b1, 4'h9, 1'b0); tick(); tick();
      n_cmp++; if (hi_level !== 3'd4) begin n_fail++; $display("FAIL bp_held_level got %0d want 4", hi_level); end
      n_cmp++; if (hi_out_byte !== 8'h12) begin n_fail++; $display("FAIL bp_held_head got %h want 12", hi_out_byte); end
      out_ready = 1'b1; tick();
      out_ready = 1'b0;
      n_cmp++; if (hi_level !== 3'd3) begin n_fail++; $display("FAIL bp_pop_level got %0d want 3", hi_level); end
      n_cmp++; if (hi_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pop_in_ready got %b want 1", hi_in_ready); end
      tick();
      drive(1'b1, 4'hA, 1'b1); tick();
      drive(1'b0, 4'h0, 1'b0);
      n_cmp++; if (hi_level !== 3'd4) begin n_fail++; $display("FAIL bp_refill_level got %0d want 4", hi_level); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (hi_out_byte !== exp_q[i]) begin n_fail++; $display("FAIL bp_order[%0d] got %h want %h", i, hi_out_byte, exp_q[i]); end
         tick();
      end
      n_cmp++; if (hi_level !== 3'd0) begin n_fail++; $display("FAIL bp_drain_level got %0d want 0", hi_level); end
      out_ready = 1'b0;
   endtask

   task automatic test_full_pop_no_write();
      logic [7:0] exp_q [4];
      exp_q = '{8'h22, 8'h33, 8'h44, 8'hE0};
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'(i / 2 + 1), 1'b0); tick();
      end
      drive(1'b1, 4'hE, 1'b1);
      out_ready = 1'b1; tick();
      n_cmp++; if (hi_level !== 3'd3) begin n_fail++; $display("FAIL full_pop_level got %0d want 3", hi_level); end
      out_ready = 1'b0; tick();
      drive(1'b0, 4'h0, 1'b0);
      n_cmp++; if (hi_level !== 3'd4) begin n_fail++; $display("FAIL full_write_level got %0d want 4", hi_level); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (hi_out_byte !== exp_q[i]) begin n_fail++; $display("FAIL full_order[%0d] got %h want %h", i, hi_out_byte, exp_q[i]); end
         if (i == 3) begin
            n_cmp++; if ({hi_out_last, hi_out_padded} !== 2'b11) begin n_fail++; $display("FAIL full_pad_flags got %b want 11", {hi_out_last, hi_out_padded}); end
            n_cmp++; if (lo_out_byte !== 8'h0E) begin n_fail++; $display("FAIL full_lo_pad got %h want 0e", lo_out_byte); end
         end
         tick();
      end
      n_cmp++; if (hi_out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain_valid got %b want 0", hi_out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_signed();
      out_ready = 1'b0;
      drive(1'b1, 4'hF, 1'b0); tick();
      drive(1'b1, 4'h0, 1'b0); tick();
      drive(1'b1, 4'h7, 1'b0); tick();
      drive(1'b1, 4'hF, 1'b0); tick();
      drive(1'b0, 4'h0, 1'b0);
      n_cmp++; if (hi_out_byte !== 8'hF0) begin n_fail++; $display("FAIL signed_byte got %h want f0", hi_out_byte); end
      n_cmp++; if (hi_out_sbyte !== -8'sd16) begin n_fail++; $display("FAIL signed_neg got %0d want -16", hi_out_sbyte); end
      n_cmp++; if (lo_out_sbyte !== 8'sd15) begin n_fail++; $display("FAIL signed_lo got %0d want 15", lo_out_sbyte); end
      out_ready = 1'b1; tick();
      n_cmp++; if (hi_out_sbyte !== 8'sd127) begin n_fail++; $display("FAIL signed_pos got %0d want 127", hi_out_sbyte); end
      tick();
      out_ready = 1'b0;
      n_cmp++; if (hi_level !== 3'd0) begin n_fail++; $display("FAIL signed_drain_level got %0d want 0", hi_level); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b1, 4'h1, 1'b0); tick();
      drive(1'b1, 4'h1, 1'b0); tick();
      drive(1'b1, 4'h2, 1'b0); tick();
      drive(1'b1, 4'h2, 1'b0); tick();
      drive(1'b1, 4'hB, 1'b0); tick();
      drive(1'b0, 4'h0, 1'b0);
      n_cmp++; if (hi_level !== 3'd2) begin n_fail++; $display("FAIL mid_pre_level got %0d want 2", hi_level); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (hi_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", hi_out_valid); end
      n_cmp++; if (hi_level !== 3'd0) begin n_fail++; $display("FAIL mid_rst_level got %0d want 0", hi_level); end
      n_cmp++; if (hi_out_byte !== 8'h00) begin n_fail++; $display("FAIL mid_rst_byte got %h want 00", hi_out_byte); end
      tick();
      rst = 1'b0; tick();
      drive(1'b1, 4'h1, 1'b0); tick();
      drive(1'b1, 4'h2, 1'b0); tick();
      drive(1'b0, 4'h0, 1'b0);
      n_cmp++; if (hi_level !== 3'd1) begin n_fail++; $display("FAIL mid_post_level got %0d want 1", hi_level); end
      n_cmp++; if (hi_out_byte !== 8'h12) begin n_fail++; $display("FAIL mid_post_byte got %h want 12", hi_out_byte); end
      n_cmp++; if (lo_out_byte !== 8'h21) begin n_fail++; $display("FAIL mid_post_lo_byte got %h want 21", lo_out_byte); end
      n_cmp++; if ({hi_out_last, hi_out_padded} !== 2'b00) begin n_fail++; $display("FAIL mid_post_flags got %b want 00", {hi_out_last, hi_out_padded}); end
      out_ready = 1'b1; tick();
      out_ready = 1'b0;
      n_cmp++; if (hi_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_drain_valid got %b want 0", hi_out_valid); end
   endtask

   initial begin
      test_reset();
      test_pairs();
      test_odd_frame();
      test_backpressure();
      test_full_pop_no_write();
      test_signed();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
